rv_mem_responder: RTL
=====================

// Module: rv_mem_responder
// PURPOSE
//  Memory-side responder for the rv core's data/instruction bus. Owns a byte-addressed RAM
//  and answers load/store requests over a valid/ready request channel and a valid/ready
//  response channel. Handles byte, half and word sizes, sign extension and a fixed number of wait states.
//  Replaces the bench-side direct byte array. The bench preloads through the mem[] hierarchy path.
// PARAMETERS
//  DEPTH        4096  RAM size in bytes (power of 2, >=4)
//  WAIT_STATES  0     extra cycles between request accept and response valid (0..15)
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   asynchronous, active-high
//  req_valid     in   1   request present
//  req_ready     out  1   responder can accept a request
//  req_we        in   1   1=store, 0=load
//  req_addr      in   32  byte address
//  req_size      in   2   0=byte, 1=half, 2=word, 3=illegal
//  req_unsigned  in   1   loads: zero-extend (LBU/LHU) instead of sign-extend
//  req_wdata     in   32  store data, right-aligned (bits [7:0] for a byte)
//  rsp_valid     out  1   response present
//  rsp_ready     in   1   initiator takes the response
//  rsp_rdata     out  32  load data, extended to 32 bits; 0 for stores and errors
//  rsp_err       out  1   misaligned, out-of-range or illegal-size request
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0,
//    rsp_err=0, wait counter=0. RAM contents are not cleared.
//  - FSM IDLE -> (WAIT if WAIT_STATES>0) -> RESP -> IDLE. One outstanding request at a time.
//  - IDLE: req_ready=1. req_valid&req_ready accepts the request and latches all req_* fields.
//    req_ready=0 in every other state.
//  - WAIT: the counter loads WAIT_STATES-1 on accept and decrements each cycle. At 0 the FSM goes to RESP.
//  - Latency from the accept edge to rsp_valid high is 1+WAIT_STATES cycles.
//  - Store commit: bytes are written on the edge that enters RESP, little-endian.
//    Byte writes addr. Half writes addr, addr+1. Word writes addr..addr+3.
//  - Load: bytes are read little-endian from the same address set and latched into rsp_rdata on entry to RESP.
//    The value is sign-extended from bit 7 or 15 unless req_unsigned=1.
//  - Error: size=3, half with addr[0]!=0, word with addr[1:0]!=0, or addr+bytes>DEPTH.
//    rsp_err=1 and rsp_rdata=0. A store with an error writes no byte.
//  - RESP: rsp_valid=1 and rsp_rdata/rsp_err stay stable until rsp_ready.
//    rsp_valid&rsp_ready -> IDLE, rsp_valid=0 on the next cycle.
//  - There is no combinational path from req_valid to req_ready, or from rsp_ready to rsp_valid.
//    The next request can be accepted at the earliest on the cycle after the response handshake.
//  - Address compare uses the full 32 bits, with no wrap-around. For example, 0xFFFFFFFF with size=word is an error.
//  - Reset mid-operation: the in-flight request is dropped and the FSM returns to IDLE.
//    A store not yet committed leaves the RAM unchanged. A store already committed stays written.
//  - req_* inputs are ignored outside IDLE.
// STRUCTURE
//  - rv_bus_pkg holds:
//    - typedef enum logic[1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_t
//    - typedef enum {IDLE, WAIT, RESP} rsp_state_t
//    - function size_bytes(size_t)
//  - Sub-module rv_mem_lane_align is combinational. It builds the load extension and the byte-enable/store-lane steering,
//    keeping this file to the FSM plus the RAM.
//  - RAM: logic [7:0] mem[DEPTH]. It must stay reachable as r.m.mem for the bench $fread preload.
// TESTING
//  - Word store 0xDEADBEEF @0x40, then load word @0x40 -> rsp_rdata=0xDEADBEEF, err=0.
//    mem[0x40..0x43]=EF,BE,AD,DE.
//  - Load byte @0x43: signed -> 0xFFFFFFDE. Unsigned -> 0x000000DE. Half @0x42 signed -> 0xFFFFDEAD.
//  - Half load @0x41 and word store @0x42 -> err=1, rdata=0, mem unchanged.
//    Word @DEPTH-2 -> err=1. Size=3 -> err=1.
//  - WAIT_STATES=3: accept at cycle N -> rsp_valid at N+4. Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held stable.
//    req_ready stays 0 until the cycle after the handshake.
//  - Back-to-back: req_valid held high with 2 requests queued -> accepts are at least 2 cycles apart (WAIT_STATES=0).
//  - Assert reset during WAIT of a store to 0x80 -> mem[0x80] unchanged, req_ready=1 and rsp_valid=0 immediately after assert.

Source files
------------

// File: rtl/rv_bus_pkg.sv
// Shared types for the rv core's memory bus: access sizes, responder FSM states
// and the byte count of each access size.
package rv_bus_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} rsp_state_t;

  function automatic logic [2:0] size_bytes(size_t sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/rv_mem_lane_align.sv
// Combinational access decode: error detection, byte enables for store steering
// and sign/zero extension of the little-endian load word.
module rv_mem_lane_align
  import rv_bus_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic        err,
  output logic [3:0]  be,
  output logic [31:0] wbytes,
  output logic [31:0] ldata
);

  size_t       sz;
  logic        misaligned;
  logic        out_of_range;
  logic [32:0] end_addr;

  assign sz = size_t'(size);

  always_comb begin
    misaligned   = 1'b0;
    be           = 4'b0000;
    ldata        = 32'h0;
    wbytes       = 32'h0;
    // 33-bit sum so addresses near 2^32 never wrap back into range
    end_addr     = {1'b0, addr} + {30'd0, size_bytes(sz)};
    case (sz)
      SZ_B: begin
        be    = 4'b0001;
        ldata = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      end
      SZ_H: begin
        misaligned = addr[0];
        be         = 4'b0011;
        ldata      = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      end
      SZ_W: begin
        misaligned = (addr[1:0] != 2'b00);
        be         = 4'b1111;
        ldata      = raw;
      end
      default: misaligned = 1'b1;
    endcase
    out_of_range = (end_addr > 33'(DEPTH));
    err          = misaligned | out_of_range;
    if (err) begin
      be    = 4'b0000;
      ldata = 32'h0;
    end
    for (int i = 0; i < 4; i++) begin
      wbytes[8*i +: 8] = be[i] ? wdata[8*i +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/rv_mem_responder.sv
// Byte-addressed RAM responder for the rv core bus: one outstanding request,
// fixed wait states, store commit / load capture on entry to RESP.
module rv_mem_responder
  import rv_bus_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // req_ready and rsp_valid are pure functions of the FSM state (no input-to-output paths).
  localparam int AW = $clog2(DEPTH);

  rsp_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [7:0]  mem [DEPTH];

  logic        in_idle, accept, enter_resp;
  logic        sel_we, sel_uns;
  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_size;
  logic [AW-1:0] base;
  logic [31:0] raw;
  logic        err;
  logic [3:0]  be;
  logic [31:0] wbytes, ldata;

  assign in_idle   = (state_q == IDLE);
  assign accept    = req_valid & in_idle;
  assign req_ready = in_idle;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

  // With no wait states the commit edge is the accept edge, so live inputs are used.
  assign sel_we    = in_idle ? req_we       : we_q;
  assign sel_addr  = in_idle ? req_addr     : addr_q;
  assign sel_size  = in_idle ? req_size     : size_q;
  assign sel_uns   = in_idle ? req_unsigned : uns_q;
  assign sel_wdata = in_idle ? req_wdata    : wdata_q;
  assign base      = sel_addr[AW-1:0];

  always_comb begin
    raw = 32'h0;
    for (int i = 0; i < 4; i++) begin
      raw[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  rv_mem_lane_align #(.DEPTH(DEPTH)) u_align (
    .addr        (sel_addr),
    .size        (sel_size),
    .is_unsigned (sel_uns),
    .wdata       (sel_wdata),
    .raw         (raw),
    .err         (err),
    .be          (be),
    .wbytes      (wbytes),
    .ldata       (ldata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        err_q   <= err;
        rdata_q <= sel_we ? 32'h0 : ldata;
      end
    end
  end

  // RAM is never cleared; a reset edge suppresses any commit in flight.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && sel_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[base + AW'(i)] <= wbytes[8*i +: 8];
      end
    end
  end

endmodule
